// File: rtl/booth_iter_mul_if.sv
// Operand/result handshake bundle for the iterative Booth multiplier.
// The master side drives operands and result acceptance; the slave side is the multiplier.
interface booth_iter_mul_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_lo;
  logic [WIDTH-1:0] out_hi;

  modport master (
    output in_valid, in_signed, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_lo, out_hi
  );

  modport slave (
    input  in_valid, in_signed, in_x, in_y, out_ready,
    output in_ready, out_valid, out_lo, out_hi
  );
endinterface

// File: rtl/booth_iter_mul.sv
// Iterative radix-4 Booth multiplier: one partial product (0/+-X/+-2X) per cycle,
// accumulated into a {high, Y} shift register; fixed latency of WIDTH/2+1 iterations.
module booth_iter_mul #(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  booth_iter_mul_if.slave   bus
);
  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER);
  localparam int XW   = WIDTH + 2;  // extended operand width
  localparam int AW   = WIDTH + 4;  // accumulator high part width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [XW-1:0]   x_reg;
  logic [XW-1:0]   y_reg;
  logic            y_prev;
  logic [AW-1:0]   acc;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;

  logic            accept;
  logic            step;
  logic            last_iter;
  logic            in_ready_c;
  logic            out_valid_c;

  logic [2:0]      window;
  logic            pp_zero;
  logic            pp_two;
  logic            pp_neg;
  logic [AW-1:0]   x1;
  logic [AW-1:0]   x2;
  logic [AW-1:0]   pp_mag;
  logic [AW-1:0]   pp_add;
  logic [AW-1:0]   acc_sum;
  logic [AW-1:0]   acc_next;
  logic [XW-1:0]   y_next;
  logic            y_prev_next;
  logic            ext_x;
  logic            ext_y;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  assign last_iter = (cnt == CW'(ITER - 1));

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_c = !flush;
        if (bus.in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid_c = !flush;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A flushed result is never offered, so a same-cycle out_ready cannot retire it.
    if (flush) state_next = IDLE;
  end

  assign accept = (state == IDLE) && bus.in_valid && !flush;
  assign step   = (state == BUSY) && !flush;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_lo    = res_lo;
  assign bus.out_hi    = res_hi;

  // ---------------------------------------------------------------------------
  // Booth recoding and accumulate
  // ---------------------------------------------------------------------------
  assign window = {y_reg[1], y_reg[0], y_prev};

  always_comb begin
    pp_zero = 1'b0;
    pp_two  = 1'b0;
    pp_neg  = 1'b0;
    unique case (window)
      3'b000, 3'b111: pp_zero = 1'b1;
      3'b001, 3'b010: pp_zero = 1'b0;
      3'b011:         pp_two  = 1'b1;
      3'b100: begin
        pp_two = 1'b1;
        pp_neg = 1'b1;
      end
      default:        pp_neg  = 1'b1;  // 101, 110
    endcase
  end

  assign x1     = {{2{x_reg[XW-1]}}, x_reg};
  assign x2     = {x_reg[XW-1], x_reg, 1'b0};
  assign pp_mag = pp_zero ? '0 : (pp_two ? x2 : x1);

  // Subtraction folds into the same adder: invert the operand and inject carry-in.
  assign pp_add  = pp_mag ^ {AW{pp_neg}};
  assign acc_sum = acc + pp_add + AW'(pp_neg);

  assign acc_next    = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
  assign y_next      = {acc_sum[1:0], y_reg[XW-1:2]};
  assign y_prev_next = y_reg[1];

  assign ext_x = bus.in_signed & bus.in_x[WIDTH-1];
  assign ext_y = bus.in_signed & bus.in_y[WIDTH-1];

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      x_reg  <= '0;
      y_reg  <= '0;
      y_prev <= 1'b0;
      acc    <= '0;
      res_lo <= '0;
      res_hi <= '0;
    end else if (accept) begin
      x_reg  <= {{2{ext_x}}, bus.in_x};
      y_reg  <= {{2{ext_y}}, bus.in_y};
      y_prev <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      y_reg  <= y_next;
      y_prev <= y_prev_next;
      cnt    <= last_iter ? '0 : cnt + CW'(1);
      // After the final shift the low 2*WIDTH product bits straddle Y and the accumulator.
      if (last_iter) begin
        res_lo <= y_next[WIDTH-1:0];
        res_hi <= {acc_next[WIDTH-3:0], y_next[XW-1:WIDTH]};
      end
    end else if (flush) begin
      cnt <= '0;
    end
  end
endmodule

// File: tb/tb_booth_iter_mul.sv
// Scoreboard bench for booth_iter_mul: stimulus pushes reference products, a monitor
// pops and compares on each delivered result and checks the fixed latency.
module tb_booth_iter_mul;
  localparam int W   = 64;
  localparam int LAT = 34;
  localparam int N_RAND = 1000;

  typedef logic [2*W-1:0] prod_t;
  typedef struct {
    prod_t prod;
    int    acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  logic flush;

  booth_iter_mul_if #(.WIDTH(W)) bus ();

  booth_iter_mul #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   rand_ready = 1'b0;
  bit   prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input prod_t act, input prod_t req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Reference: exact product of the extended operands, truncated to 2*W bits.
  function automatic prod_t ref_mul(input bit sgn, input logic [W-1:0] x, input logic [W-1:0] y);
    prod_t xe, ye;
    xe = sgn ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ye = sgn ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      4:       return W'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: latency on each rising out_valid, data on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        check("valid_expected", prod_t'(sb.size() != 0), prod_t'(1));
        if (sb.size() != 0)
          check("latency", prod_t'(cyc - sb[0].acc_cyc), prod_t'(LAT));
      end
      if (bus.out_valid && bus.out_ready && !flush && sb.size() != 0) begin
        e = sb.pop_front();
        check("product", {bus.out_hi, bus.out_lo}, e.prod);
      end
      prev_valid = bus.out_valid;
    end
  end

  // Random consumer back-pressure during the random phase.
  always begin
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Presents one operand pair, waits for acceptance, records the expectation.
  // Returns 1 time unit after the accept edge.
  task automatic issue(input bit sgn, input logic [W-1:0] x, input logic [W-1:0] y,
                       input prod_t expv, input bit garbage);
    int   waited;
    exp_t e;
    waited = 0;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.in_signed = sgn;
    bus.in_x      = x;
    bus.in_y      = y;
    @(negedge clk);
    while (!(bus.in_ready && !flush) && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 200) begin
      check("accept_timeout", prod_t'(bus.in_ready), prod_t'(1));
      bus.in_valid = 1'b0;
      return;
    end
    e.prod    = expv;
    e.acc_cyc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Operands change right after the accept edge; the DUT must have captured them.
    bus.in_signed = ~sgn;
    bus.in_x      = {$urandom, $urandom};
    bus.in_y      = {$urandom, $urandom};
    if (garbage) begin
      bus.in_valid = 1'b1;
      repeat ($urandom_range(1, 25)) @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("drain_timeout", prod_t'(sb.size()), prod_t'(0));
  endtask

  task automatic watch_quiet(input string name, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check(name, prod_t'(seen), prod_t'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x, y, lo_h, hi_h;
    bit sgn;
    int n;

    resetn        = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;

    #1;
    check("rst_in_ready",  prod_t'(bus.in_ready),  prod_t'(1));
    check("rst_out_valid", prod_t'(bus.out_valid), prod_t'(0));
    check("rst_out_lo",    prod_t'(bus.out_lo),    prod_t'(0));
    check("rst_out_hi",    prod_t'(bus.out_hi),    prod_t'(0));
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Directed products with hand-derived results.
    issue(1'b1, 64'd3, 64'd5, {64'h0, 64'hF}, 1'b0);
    drain();
    issue(1'b1, '1, '1, {64'h0, 64'h1}, 1'b0);
    drain();
    issue(1'b0, '1, '1, {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001}, 1'b0);
    drain();
    issue(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          {64'h4000_0000_0000_0000, 64'h0}, 1'b0);
    drain();
    issue(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          {64'h4000_0000_0000_0000, 64'h0}, 1'b0);
    drain();
    issue(1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
          {64'hC000_0000_0000_0000, 64'h8000_0000_0000_0000}, 1'b0);
    drain();

    // Back-pressure: result and in_ready must hold while out_ready is low.
    bus.out_ready = 1'b0;
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    issue(1'b1, x, y, ref_mul(1'b1, x, y), 1'b0);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("bp_valid_seen", prod_t'(bus.out_valid), prod_t'(1));
    lo_h = bus.out_lo;
    hi_h = bus.out_hi;
    repeat (10) begin
      @(negedge clk);
      check("bp_valid_held",   prod_t'(bus.out_valid), prod_t'(1));
      check("bp_data_held",    {bus.out_hi, bus.out_lo}, {hi_h, lo_h});
      check("bp_in_ready_low", prod_t'(bus.in_ready), prod_t'(0));
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_after", prod_t'(bus.in_ready), prod_t'(1));
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    issue(1'b0, x, y, ref_mul(1'b0, x, y), 1'b0);
    drain();

    // flush in IDLE beats in_valid: nothing is accepted.
    @(posedge clk);
    #1;
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_signed = 1'b1;
    bus.in_x      = 64'd9;
    bus.in_y      = 64'd9;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    watch_quiet("flush_idle_no_result", 45);

    // flush at BUSY cycle 15 with in_valid high: operation dropped.
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    issue(1'b1, x, y, ref_mul(1'b1, x, y), 1'b0);
    repeat (14) @(posedge clk);
    #1;
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("flush_busy_idle",      prod_t'(bus.in_ready),  prod_t'(1));
    check("flush_busy_out_valid", prod_t'(bus.out_valid), prod_t'(0));
    watch_quiet("flush_busy_no_result", 45);
    issue(1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFA,
          {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFD6}, 1'b0);
    drain();

    // Asynchronous reset at BUSY cycle 20.
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    issue(1'b0, x, y, ref_mul(1'b0, x, y), 1'b0);
    repeat (19) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("arst_in_ready",  prod_t'(bus.in_ready),  prod_t'(1));
    check("arst_out_valid", prod_t'(bus.out_valid), prod_t'(0));
    check("arst_out_lo",    prod_t'(bus.out_lo),    prod_t'(0));
    check("arst_out_hi",    prod_t'(bus.out_hi),    prod_t'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    watch_quiet("arst_no_result", 45);

    // Random operands, random back-pressure, in_valid noise during BUSY/DONE.
    rand_ready = 1'b1;
    for (int i = 0; i < N_RAND; i++) begin
      sgn = 1'($urandom);
      x   = pick();
      y   = pick();
      issue(sgn, x, y, ref_mul(sgn, x, y), 1'($urandom));
    end
    drain();
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
